// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: edit sequencer and alarm-ring controller for the alarm clock.
//   Edit FSM walks hours -> minutes -> seconds on confirm pulses, range-checks
//   every entry, then commits either a one-cycle time load or the alarm regs.
//   Alarm FSM rings on a rising edge of the alarm match for RING_SECS seconds.
// Ports:
//   clk, rst                      clock, async active-high reset
//   tick_1hz_i, confirm_i         one-cycle enables (1 Hz, debounced confirm)
//   mode_i                        00/11 run, 01 set time, 10 set alarm
//   data_i                        user-entered field value
//   alarm_en_i                    alarm arm switch (level)
//   cur_h_i/cur_m_i/cur_s_i       current time from timekeeping datapath
//   freeze_o                      hold timekeeping while editing time
//   ld_time_o, set_h/m/s_o        one-cycle load strobe and committed time
//   edit_field_o                  00 none, 01 h, 10 m, 11 s
//   err_o                         one-cycle pulse on rejected entry
//   alarm_h/m/s_o                 stored alarm time
//   ringing_o                     alarm active
module clock_set_ctrl #(
    parameter int unsigned RING_SECS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz_i,
    input  logic       confirm_i,
    input  logic [1:0] mode_i,
    input  logic [5:0] data_i,
    input  logic       alarm_en_i,
    input  logic [4:0] cur_h_i,
    input  logic [5:0] cur_m_i,
    input  logic [5:0] cur_s_i,
    output logic       freeze_o,
    output logic       ld_time_o,
    output logic [4:0] set_h_o,
    output logic [5:0] set_m_o,
    output logic [5:0] set_s_o,
    output logic [1:0] edit_field_o,
    output logic       err_o,
    output logic [4:0] alarm_h_o,
    output logic [5:0] alarm_m_o,
    output logic [5:0] alarm_s_o,
    output logic       ringing_o
);

    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;
    localparam int unsigned CW = 6;

    typedef enum logic [2:0] {
        S_IDLE, S_EDIT_H, S_EDIT_M, S_EDIT_S, S_COMMIT, S_WAIT_EXIT
    } edit_state_e;

    typedef enum logic {A_ARMED, A_RINGING} alarm_state_e;

    edit_state_e  edit_q, edit_d;
    alarm_state_e al_q, al_d;
    logic          tgt_alarm_q, tgt_alarm_d;
    logic [HW-1:0] sh_h_q, sh_h_d, set_h_q, set_h_d, alarm_h_q, alarm_h_d;
    logic [MW-1:0] sh_m_q, sh_m_d, set_m_q, set_m_d, alarm_m_q, alarm_m_d;
    logic [MW-1:0] sh_s_q, sh_s_d, set_s_q, set_s_d, alarm_s_q, alarm_s_d;
    logic          freeze_q, freeze_d, ld_time_q, ld_time_d, err_q, err_d;
    logic [1:0]    edit_field_q, edit_field_d;
    logic          match_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_ok_c, match_c;

    // Still in the mode that started the edit (01 for time, 10 for alarm).
    assign mode_ok_c = (mode_i == (tgt_alarm_q ? 2'b10 : 2'b01));

    assign match_c = alarm_en_i && (cur_h_i == alarm_h_q) &&
                     (cur_m_i == alarm_m_q) && (cur_s_i == alarm_s_q);

    // Edit FSM next state; registered outputs are derived from the next state.
    always_comb begin
        edit_d      = edit_q;
        tgt_alarm_d = tgt_alarm_q;
        sh_h_d      = sh_h_q;
        sh_m_d      = sh_m_q;
        sh_s_d      = sh_s_q;
        set_h_d     = set_h_q;
        set_m_d     = set_m_q;
        set_s_d     = set_s_q;
        alarm_h_d   = alarm_h_q;
        alarm_m_d   = alarm_m_q;
        alarm_s_d   = alarm_s_q;
        ld_time_d   = 1'b0;
        err_d       = 1'b0;
        unique case (edit_q)
            S_IDLE: begin
                if (mode_i == 2'b01 || mode_i == 2'b10) begin
                    tgt_alarm_d = mode_i[1];
                    edit_d      = S_EDIT_H;
                end
            end
            S_EDIT_H: begin
                if (!mode_ok_c) begin
                    edit_d = S_IDLE;
                end else if (confirm_i) begin
                    if (data_i <= 6'd23) begin
                        sh_h_d = data_i[HW-1:0];
                        edit_d = S_EDIT_M;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_EDIT_M: begin
                if (!mode_ok_c) begin
                    edit_d = S_IDLE;
                end else if (confirm_i) begin
                    if (data_i <= 6'd59) begin
                        sh_m_d = data_i;
                        edit_d = S_EDIT_S;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_EDIT_S: begin
                if (!mode_ok_c) begin
                    edit_d = S_IDLE;
                end else if (confirm_i) begin
                    if (data_i <= 6'd59) begin
                        sh_s_d = data_i;
                        edit_d = S_COMMIT;
                        // Time load strobe must be visible during COMMIT itself.
                        if (!tgt_alarm_q) begin
                            ld_time_d = 1'b1;
                            set_h_d   = sh_h_q;
                            set_m_d   = sh_m_q;
                            set_s_d   = data_i;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                if (tgt_alarm_q) begin
                    alarm_h_d = sh_h_q;
                    alarm_m_d = sh_m_q;
                    alarm_s_d = sh_s_q;
                end
                edit_d = S_WAIT_EXIT;
            end
            S_WAIT_EXIT: begin
                if (!mode_ok_c) begin
                    edit_d = S_IDLE;
                end
            end
            default: edit_d = S_IDLE;
        endcase

        freeze_d = !tgt_alarm_d && (edit_d == S_EDIT_H || edit_d == S_EDIT_M ||
                                    edit_d == S_EDIT_S || edit_d == S_COMMIT);
        unique case (edit_d)
            S_EDIT_H: edit_field_d = 2'b01;
            S_EDIT_M: edit_field_d = 2'b10;
            S_EDIT_S: edit_field_d = 2'b11;
            default:  edit_field_d = 2'b00;
        endcase
    end

    // Alarm FSM: ring on match rising edge, stop after RING_SECS ticks or disarm.
    always_comb begin
        al_d  = al_q;
        cnt_d = cnt_q;
        unique case (al_q)
            A_ARMED: begin
                if (match_c && !match_prev_q) begin
                    al_d  = A_RINGING;
                    cnt_d = '0;
                end
            end
            A_RINGING: begin
                if (!alarm_en_i) begin
                    al_d = A_ARMED;
                end else if (tick_1hz_i) begin
                    if (cnt_q == CW'(RING_SECS - 1)) begin
                        al_d = A_ARMED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: al_d = A_ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edit_q       <= S_IDLE;
            tgt_alarm_q  <= 1'b0;
            sh_h_q       <= '0;
            sh_m_q       <= '0;
            sh_s_q       <= '0;
            set_h_q      <= '0;
            set_m_q      <= '0;
            set_s_q      <= '0;
            alarm_h_q    <= '0;
            alarm_m_q    <= '0;
            alarm_s_q    <= '0;
            freeze_q     <= 1'b0;
            ld_time_q    <= 1'b0;
            err_q        <= 1'b0;
            edit_field_q <= 2'b00;
            al_q         <= A_ARMED;
            match_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            edit_q       <= edit_d;
            tgt_alarm_q  <= tgt_alarm_d;
            sh_h_q       <= sh_h_d;
            sh_m_q       <= sh_m_d;
            sh_s_q       <= sh_s_d;
            set_h_q      <= set_h_d;
            set_m_q      <= set_m_d;
            set_s_q      <= set_s_d;
            alarm_h_q    <= alarm_h_d;
            alarm_m_q    <= alarm_m_d;
            alarm_s_q    <= alarm_s_d;
            freeze_q     <= freeze_d;
            ld_time_q    <= ld_time_d;
            err_q        <= err_d;
            edit_field_q <= edit_field_d;
            al_q         <= al_d;
            match_prev_q <= match_c;
            cnt_q        <= cnt_d;
        end
    end

    assign freeze_o     = freeze_q;
    assign ld_time_o    = ld_time_q;
    assign set_h_o      = set_h_q;
    assign set_m_o      = set_m_q;
    assign set_s_o      = set_s_q;
    assign edit_field_o = edit_field_q;
    assign err_o        = err_q;
    assign alarm_h_o    = alarm_h_q;
    assign alarm_m_o    = alarm_m_q;
    assign alarm_s_o    = alarm_s_q;
    assign ringing_o    = (al_q == A_RINGING);

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Sequencing controller for the Lab 4 alarm clock. It decodes the user's mode selector and debounced confirm pulses into a field-by-field edit sequence (hours → minutes → seconds) and range-checks every entry. A completed edit is committed either as a single load strobe to the timekeeping counter or into the alarm registers held here. The block also owns the alarm-ring state machine that drives the alarm LED/sounder enable. It sits between the debouncer/1 Hz enable generator and the timekeeping datapath.

## Interface

- RING_SECS, 30, number of 1 Hz ticks the alarm rings before self-clearing (1..63)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- tick_1hz  input  1  one-cycle enable pulse, once per second, synchronous to clk
- confirm  input  1  one-cycle debounced confirm pulse, synchronous to clk
- mode  input  2  00 run, 01 set time, 10 set alarm, 11 run
- data  input  6  value entered by user switches
- alarm_en  input  1  alarm arm switch (level)
- cur_h / cur_m / cur_s  input  5/6/6  current 24 h time from timekeeping datapath
- freeze  output  1  high: timekeeping datapath must not count
- ld_time  output  1  one-cycle strobe: datapath loads set_h/set_m/set_s
- set_h / set_m / set_s  output  5/6/6  committed time value, valid when ld_time high
- edit_field  output  2  00 none, 01 hours, 10 minutes, 11 seconds (display blink select)
- err  output  1  one-cycle pulse: rejected out-of-range entry
- alarm_h / alarm_m / alarm_s  output  5/6/6  stored alarm time
- ringing  output  1  alarm active (drives LED/sounder enable)

## Operation

- Edit FSM states: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT, WAIT_EXIT.
- IDLE: when mode is 01 or 10, latch target (time/alarm) from mode[1] and go to EDIT_H. Confirm in IDLE is ignored.
- EDIT_x on confirm:
  - Range limits: hours data ≤ 23 (data[5] must be 0); minutes/seconds data ≤ 59.
  - In range: capture data into the shadow field and advance to the next state (EDIT_S advances to COMMIT).
  - Out of range: err=1 for one cycle, shadow unchanged, stay in state.
- COMMIT, one cycle:
  - Target time: ld_time=1, set_* = shadow.
  - Target alarm: alarm_* ← shadow; ld_time stays 0.
  - Then go to WAIT_EXIT.
- WAIT_EXIT: stay until mode differs from the latched target mode, then go to IDLE. This prevents an immediate re-entry into edit.
- Abort: in EDIT_*, if mode differs from the latched target mode, go to IDLE next cycle with no commit. Shadow registers retain their stale values.
- freeze=1 in EDIT_* and COMMIT only when target is time; 0 otherwise.
- edit_field encodes the current EDIT state; 00 in all other states.
- Alarm FSM states: ARMED, RINGING.
  - match = alarm_en & (cur_* == alarm_*).
  - ARMED → RINGING on a rising edge of match (match high and its registered previous value low).
  - RINGING counts tick_1hz pulses. It returns to ARMED on the cycle after RING_SECS ticks are counted, or on the cycle after alarm_en=0, whichever comes first.
  - The match edge detector prevents re-triggering within the matched second.
- ringing = (alarm state == RINGING). The alarm FSM runs independently of the edit FSM.

## Timing

- Reset (async, immediate), all values 0: edit FSM IDLE, alarm FSM ARMED, shadow and alarm_* = 0, freeze=0, ld_time=0, set_*=0, edit_field=00, err=0, ringing=0, match history=0, ring counter=0.
- All outputs are registered.
- Confirm sampled in cycle N: state, edit_field and err update in cycle N+1. The EDIT_S confirm gives COMMIT in N+1 (ld_time high N+1 only) and WAIT_EXIT in N+2.
- freeze rises the cycle after mode=01 is seen in IDLE. It falls the cycle after COMMIT, or the cycle after an abort.
- Confirm and a mode change in the same cycle: abort wins; no capture, no err.
- A tick_1hz in the same cycle that RINGING is entered is not counted.
- alarm_en falling and the final tick in the same cycle: ARMED next cycle (same outcome either way).
- A commit that sets the alarm equal to the current time triggers ringing only through a match edge, i.e. the cycle after alarm_* update if alarm_en=1.
- Ring counter width: 6 bits; cleared on entry to RINGING.

## Test plan

- Time set: mode=01, confirm with data 13, 45, 07 → edit_field 01→10→11. One ld_time pulse with set_h=13, set_m=45, set_s=07. freeze high from entry through COMMIT. WAIT_EXIT until mode=00.
- Range check: in EDIT_H confirm data=24 → err pulse, stay EDIT_H. In EDIT_M confirm 60 → err. Confirm 59 → advances.
- Abort: mode=10, confirm hours=6, then mode→00 before seconds → IDLE, alarm_* unchanged (0), no ld_time, err never asserted.
- Alarm: set alarm 00:01:00, alarm_en=1, drive cur to 00:01:00 → ringing next cycle. Clears exactly after 30 ticks with RING_SECS=30. Holding cur constant does not retrigger.
- Alarm kill and reset: ringing active, alarm_en→0 → ringing low next cycle. Assert rst mid-EDIT_M → all outputs 0 immediately, FSM IDLE.
